v_issue_queue: RTL
==================

# v_issue_queue

Instruction buffer and single-issue sequencer between the base processor and the vector coprocessor top (`carrd_integrated`).
- Accepts 32-bit instructions from the base processor over a valid/ready handshake and discards anything that is not a vector opcode.
- Presents one instruction at a time, held stable, on the coprocessor's `op_instr_base` input.
- Retires it when the coprocessor's execution units report done, or on timeout.
- Drives NOP (32'h0) whenever nothing is issued, so the combinational vector decoder sees no operation.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- TIMEOUT, 64: maximum cycles an issued instruction may wait for done; must be at least 2.
- clk  in  1  single clock, rising-edge.
- nrst  in  1  asynchronous, active-high reset (1 = reset asserted).
- instr_valid  in  1  base processor offers `instr_in`.
- instr_in  in  32  raw instruction word.
- instr_ready  out  1  queue can accept; equals !full.
- flush  in  1  synchronous flush of queue and in-flight instruction.
- exec_done  in  1  OR of done_valu/done_vmul/done_vred/done_vsldu/done_vlsu, formed at the top level.
- issue_instr  out  32  instruction to coprocessor; 32'h0 when not issuing.
- issue_valid  out  1  `issue_instr` is live.
- retired  out  1  one-cycle pulse when the issued instruction completes normally.
- timeout_err  out  1  sticky; set when TIMEOUT expires.
- busy  out  1  queue non-empty or state != IDLE.
- count  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- Vector opcodes (instr_in[6:0]) are: OP-V 7'b1010111, LOAD-FP 7'b0000111, STORE-FP 7'b0100111.
- On handshake with any other opcode, the word is acknowledged and dropped. No enqueue, count unchanged.
- vsetvli/vsetvl (OP-V with funct3 3'b111) is a config instruction. It retires after exactly one BUSY cycle, independent of exec_done.
- The FIFO is circular with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- FSM states are IDLE, BUSY.
- IDLE:
  - If count>0: load the head into the issue register, pop it, clear the timer, go BUSY.
  - Otherwise remain in IDLE.
- BUSY:
  - issue_valid=1 and issue_instr = issue register; the value is stable for the whole state.
  - The timer increments every cycle.
  - Config instruction: go IDLE at the next edge and pulse retired.
  - Non-config instruction with exec_done=1: go IDLE and pulse retired.
  - Timer reaching TIMEOUT-1 without done: set timeout_err, go IDLE, no retired pulse.
- exec_done seen in IDLE is ignored.
- A push and a pop in the same cycle leave count unchanged.
- A push while full is impossible, because instr_ready=0.
- flush=1: count, both pointers and the timer are cleared; state goes IDLE; issue_instr goes to 0; no retired pulse. flush has priority over a push in the same cycle; that instruction is lost, but it is still acknowledged if instr_ready=1.
- timeout_err is cleared only by nrst.

## Timing
- Reset values: state=IDLE, pointers=0, count=0, issue register=32'h0, issue_valid=0, retired=0, timeout_err=0, busy=0, instr_ready=1.
- Reset acts asynchronously on assertion. Deassertion is synchronous to clk at the top level.
- Enqueue at edge N: count is updated after edge N. IDLE pops at edge N+1, so issue_valid is high after edge N+1.
- Minimum issue latency is therefore 2 edges after the handshake.
- Back-to-back instructions have at least one IDLE (NOP) cycle between them.
- The decoder sees 32'h0 for at least one cycle between instructions, which clears reg_wr_en.
- Config throughput: one instruction per 2 cycles.
- Timeout retire happens TIMEOUT cycles after the BUSY entry edge.
- retired is registered and asserted in the cycle after the done condition is sampled.
- Reset asserted mid-BUSY: outputs return to reset values immediately; the instruction is lost.

## Structure
- v_pkg additions:
  - localparams OPC_OPV, OPC_LOADFP, OPC_STOREFP and F3_VCFG.
  - typedef enum logic {IDLE, BUSY} issue_state_t.
  - function is_vector_op(logic [31:0]).
- Sub-module v_instr_fifo (parameter DEPTH; push/pop/flush, count, full/empty). The FSM, timer and opcode filter live in v_issue_queue.

## Test plan
- Reset then idle: nrst=1 for 2 cycles, then 0 → instr_ready=1, issue_instr=32'h0, busy=0, count=0.
- Single vadd: push 32'h02008057 → issue_valid high 2 edges later with issue_instr=32'h02008057; assert exec_done 5 cycles later → retired pulses once, issue_instr=0 the next cycle.
- Fill and drain with DEPTH=4, exec_done held low:
  - Push 6 vector words → instr_ready drops after 5 accepted (1 in flight, 4 queued), count=4.
  - Then pulse exec_done → FIFO order preserved and count decrements.
- Filter and config:
  - Push 32'h00000013 (addi) → acknowledged, count stays 0.
  - Push vsetvli 32'h0082F057 → retired one cycle after issue, exec_done=0 throughout.
- Timeout and flush:
  - Issue a vector word, never assert done → timeout_err=1 TIMEOUT cycles after BUSY entry, retired=0, next entry issues.
  - Assert flush with 3 queued → count=0, issue_valid=0 next cycle, timeout_err still 1.

Source files
------------

// File: rtl/v_pkg.sv
// rtl/v_pkg.sv - opcode constants, issue FSM state type and decode helpers
package v_pkg;

  localparam logic [6:0] OPC_OPV     = 7'b1010111;
  localparam logic [6:0] OPC_LOADFP  = 7'b0000111;
  localparam logic [6:0] OPC_STOREFP = 7'b0100111;
  localparam logic [2:0] F3_VCFG     = 3'b111;

  typedef enum logic {IDLE, BUSY} issue_state_t;

  function automatic logic is_vector_op(input logic [31:0] instr);
    return (instr[6:0] == OPC_OPV) || (instr[6:0] == OPC_LOADFP) ||
           (instr[6:0] == OPC_STOREFP);
  endfunction

  // vsetvli/vsetvl retire on their own; the execution units never report them
  function automatic logic is_vcfg_op(input logic [31:0] instr);
    return (instr[6:0] == OPC_OPV) && (instr[14:12] == F3_VCFG);
  endfunction

endpackage

// File: rtl/v_instr_fifo.sv
// rtl/v_instr_fifo.sv - circular instruction FIFO with occupancy count and flush
module v_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/v_issue_queue.sv
// rtl/v_issue_queue.sv - vector instruction buffer and single-issue sequencer
// Filters non-vector opcodes, issues one instruction at a time, retires on done/config/timeout.
module v_issue_queue
  import v_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 64,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          instr_valid,
  input  logic [31:0]   instr_in,
  output logic          instr_ready,
  input  logic          flush,
  input  logic          exec_done,
  output logic [31:0]   issue_instr,
  output logic          issue_valid,
  output logic          retired,
  output logic          timeout_err,
  output logic          busy,
  output logic [CW-1:0] count
);

  localparam int TW = $clog2(TIMEOUT);

  issue_state_t  state_q;
  logic [31:0]   issue_q;
  logic [TW-1:0] timer_q;
  logic          cfg_q;
  logic          retired_q;
  logic          timeout_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;

  // Non-vector words are still acknowledged through instr_ready, just never stored.
  assign instr_ready = !fifo_full;
  assign push = instr_valid && !fifo_full && !flush && is_vector_op(instr_in);
  assign pop  = (state_q == IDLE) && !fifo_empty && !flush;

  v_instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst     (nrst),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (instr_in),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q   <= IDLE;
      issue_q   <= '0;
      timer_q   <= '0;
      cfg_q     <= 1'b0;
      retired_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      retired_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        issue_q <= '0;
        timer_q <= '0;
        cfg_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!fifo_empty) begin
              issue_q <= fifo_head;
              cfg_q   <= is_vcfg_op(fifo_head);
              timer_q <= '0;
              state_q <= BUSY;
            end
          end
          BUSY: begin
            timer_q <= timer_q + 1'b1;
            // Leaving BUSY always clears the issue register so the decoder sees a NOP gap.
            if (cfg_q || exec_done) begin
              retired_q <= 1'b1;
              issue_q   <= '0;
              state_q   <= IDLE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
              timeout_q <= 1'b1;
              issue_q   <= '0;
              state_q   <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign issue_instr = issue_q;
  assign issue_valid = (state_q == BUSY);
  assign retired     = retired_q;
  assign timeout_err = timeout_q;
  assign busy        = !fifo_empty || (state_q == BUSY);
  assign count       = fifo_count;

endmodule
